// File: rtl/mem_access_stage_if.sv
// EX/MEM-to-MEM/WB bus of the data-memory access stage.
// stall_out high: upstream must hold its instruction; it is released to MEM/WB in the first cycle stall_out is low.
interface mem_access_stage_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 5
);
  logic [DSIZE-1:0] alu_result_in;
  logic [DSIZE-1:0] wdata_in;
  logic             memRead_in;
  logic             memWrite_in;
  logic             memToReg_in;
  logic             WriteEn_in;
  logic [ASIZE-1:0] waddr_in;

  logic [DSIZE-1:0] alu_result_out;
  logic [DSIZE-1:0] rdata_DM_out;
  logic             memToReg_out;
  logic [ASIZE-1:0] waddr_out;
  logic             WriteEn_out;
  logic             stall_out;
  logic             err_out;

  modport master (
    output alu_result_in, wdata_in, memRead_in, memWrite_in, memToReg_in, WriteEn_in, waddr_in,
    input  alu_result_out, rdata_DM_out, memToReg_out, waddr_out, WriteEn_out, stall_out, err_out
  );

  modport slave (
    input  alu_result_in, wdata_in, memRead_in, memWrite_in, memToReg_in, WriteEn_in, waddr_in,
    output alu_result_out, rdata_DM_out, memToReg_out, waddr_out, WriteEn_out, stall_out, err_out
  );
endinterface

// File: rtl/mem_access_stage.sv
// Data-memory access stage: fixed-latency memory FSM that stalls upstream during loads/stores.
// Optional out-of-range address trapping is enabled by defining DM_RANGE_CHECK_EN.
module mem_access_stage #(
  parameter int DSIZE       = 16,
  parameter int ASIZE       = 5,
  parameter int MEM_AW      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_stage_if.slave bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic              req;
  logic              latch;
  logic              do_access;
  logic              stall;
  logic              access_en;
  logic [MEM_AW-1:0] addr_q;
  logic [DSIZE-1:0]  wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic [DSIZE-1:0]  rdata_q;
  logic [DSIZE-1:0]  mem [0:(1<<MEM_AW)-1];

  assign req = bus.memRead_in | bus.memWrite_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // DONE never looks at req: the same instruction is still on the inputs then.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch      = 1'b0;
    do_access  = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall      = 1'b1;
          latch      = 1'b1;
          cnt_next   = 4'(WAIT_CYCLES - 1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) begin
          do_access  = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (latch) begin
      addr_q  <= bus.alu_result_in[MEM_AW-1:0];
      wdata_q <= bus.wdata_in;
      rd_q    <= bus.memRead_in;
      wr_q    <= bus.memWrite_in;
    end
  end

`ifdef DM_RANGE_CHECK_EN
  logic oob_q;
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oob_q <= 1'b0;
      err_q <= 1'b0;
    end else if (latch) begin
      oob_q <= |bus.alu_result_in[DSIZE-1:MEM_AW];
      err_q <= err_q | (|bus.alu_result_in[DSIZE-1:MEM_AW]);
    end
  end

  assign access_en   = ~oob_q;
  assign bus.err_out = err_q;
`else
  assign access_en   = 1'b1;
  assign bus.err_out = 1'b0;
`endif

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_access && wr_q && access_en) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Same-edge read with the write above gives read-before-write on a combined op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (do_access && rd_q) begin
      rdata_q <= access_en ? mem[addr_q] : '0;
    end
  end

  assign bus.alu_result_out = bus.alu_result_in;
  assign bus.memToReg_out   = bus.memToReg_in;
  assign bus.waddr_out      = bus.waddr_in;
  assign bus.rdata_DM_out   = rdata_q;
  assign bus.stall_out      = stall & rst;
  assign bus.WriteEn_out    = bus.WriteEn_in & ~bus.stall_out;
  assign state_dbg          = state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops against a memory model.
module tb_mem_access_stage;
  localparam int DSIZE  = 16;
  localparam int ASIZE  = 5;
  localparam int MEM_AW = 8;
  localparam int W      = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DSIZE-1:0] ref_mem [int];
  logic [DSIZE-1:0] ref_rdata;
  logic [DSIZE-1:0] exp_q [$];
  logic             err_exp;

  int               op_stall;
  int               op_start;
  logic             op_leak;
  logic             op_we;
  logic [DSIZE-1:0] op_rdata;

  mem_access_stage_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

  mem_access_stage #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .MEM_AW(MEM_AW), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic drive_idle();
    bus.memRead_in    = 1'b0;
    bus.memWrite_in   = 1'b0;
    bus.WriteEn_in    = 1'b0;
    bus.memToReg_in   = 1'b0;
    bus.waddr_in      = '0;
    bus.alu_result_in = '0;
    bus.wdata_in      = '0;
  endtask

  // Called just after a rising edge with the stage in IDLE; returns after the instruction is released.
  task automatic mem_op(input logic rd, input logic wr, input logic [DSIZE-1:0] addr,
                        input logic [DSIZE-1:0] wd);
    bus.memRead_in    = rd;
    bus.memWrite_in   = wr;
    bus.alu_result_in = addr;
    bus.wdata_in      = wd;
    bus.WriteEn_in    = 1'b1;
    bus.memToReg_in   = rd;
    bus.waddr_in      = 5'($urandom_range(1, 31));
    op_stall = 0;
    op_start = -1;
    op_leak  = 1'b0;
    @(negedge clk);
    while (bus.stall_out === 1'b1 && op_stall < 40) begin
      if (op_start < 0) op_start = cyc;
      if (bus.WriteEn_out !== 1'b0) op_leak = 1'b1;
      op_stall++;
      @(negedge clk);
    end
    op_rdata = bus.rdata_DM_out;
    op_we    = bus.WriteEn_out;
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  // scenario tasks
  task automatic test_reset();
    drive_idle();
    bus.memRead_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_out); end
    checks++; if (bus.rdata_DM_out !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata_DM_out); end
    checks++; if (bus.err_out !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err_out); end
    drive_idle();
    rst = 1'b1;
    ref_rdata = '0;
    err_exp   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_passthrough();
    logic [DSIZE-1:0] a;
    logic [ASIZE-1:0] wa;
    logic             we;
    logic             m2r;
    bus.WriteEn_in = 1'b1; bus.waddr_in = 5'd5; bus.alu_result_in = 16'h1234; bus.memToReg_in = 1'b0;
    #1;
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL pass_stall: got %b expected 0", bus.stall_out); end
    checks++; if (bus.WriteEn_out !== 1'b1) begin errors++; $display("FAIL pass_we: got %b expected 1", bus.WriteEn_out); end
    checks++; if (bus.alu_result_out !== 16'h1234) begin errors++; $display("FAIL pass_alu: got %h expected 1234", bus.alu_result_out); end
    checks++; if (bus.waddr_out !== 5'd5) begin errors++; $display("FAIL pass_waddr: got %h expected 05", bus.waddr_out); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      a = 16'($urandom); wa = 5'($urandom); we = 1'($urandom); m2r = 1'($urandom);
      bus.alu_result_in = a; bus.waddr_in = wa; bus.WriteEn_in = we; bus.memToReg_in = m2r;
      #1;
      checks++;
      if (bus.alu_result_out !== a || bus.waddr_out !== wa || bus.WriteEn_out !== we ||
          bus.memToReg_out !== m2r || bus.stall_out !== 1'b0 || bus.rdata_DM_out !== ref_rdata) begin
        errors++;
        $display("FAIL pass_rand: got alu=%h waddr=%h we=%b m2r=%b stall=%b rdata=%h expected alu=%h waddr=%h we=%b m2r=%b stall=0 rdata=%h",
                 bus.alu_result_out, bus.waddr_out, bus.WriteEn_out, bus.memToReg_out, bus.stall_out,
                 bus.rdata_DM_out, a, wa, we, m2r, ref_rdata);
      end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_store_load();
    mem_op(1'b0, 1'b1, 16'h0010, 16'hDEAD);
    ref_mem[16'h10] = 16'hDEAD;
    checks++; if (op_stall != W + 1) begin errors++; $display("FAIL st_stall_len: got %0d expected %0d", op_stall, W + 1); end
    checks++; if (op_leak !== 1'b0) begin errors++; $display("FAIL st_we_stalled: got %b expected 0", op_leak); end
    checks++; if (op_we !== 1'b1) begin errors++; $display("FAIL st_we_done: got %b expected 1", op_we); end
    checks++; if (op_rdata !== ref_rdata) begin errors++; $display("FAIL st_rdata_hold: got %h expected %h", op_rdata, ref_rdata); end
    mem_op(1'b1, 1'b0, 16'h0010, 16'h0000);
    ref_rdata = ref_mem[16'h10];
    checks++; if (op_stall != W + 1) begin errors++; $display("FAIL ld_stall_len: got %0d expected %0d", op_stall, W + 1); end
    checks++; if (op_leak !== 1'b0) begin errors++; $display("FAIL ld_we_stalled: got %b expected 0", op_leak); end
    checks++; if (op_rdata !== 16'hDEAD) begin errors++; $display("FAIL ld_rdata: got %h expected dead", op_rdata); end
  endtask

  task automatic test_rmw();
    mem_op(1'b0, 1'b1, 16'h0030, 16'h0001);
    ref_mem[16'h30] = 16'h0001;
    mem_op(1'b1, 1'b1, 16'h0030, 16'h0002);
    checks++; if (op_rdata !== 16'h0001) begin errors++; $display("FAIL rmw_old: got %h expected 0001", op_rdata); end
    ref_mem[16'h30] = 16'h0002;
    mem_op(1'b1, 1'b0, 16'h0030, 16'h0000);
    ref_rdata = ref_mem[16'h30];
    checks++; if (op_rdata !== 16'h0002) begin errors++; $display("FAIL rmw_new: got %h expected 0002", op_rdata); end
  endtask

  task automatic test_reset_mid_access();
    mem_op(1'b0, 1'b1, 16'h0020, 16'h1111);
    ref_mem[16'h20] = 16'h1111;
    bus.memWrite_in = 1'b1; bus.alu_result_in = 16'h0020; bus.wdata_in = 16'hBEEF; bus.WriteEn_in = 1'b1;
    @(negedge clk);
    checks++; if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL mid_stall_req: got %b expected 1", bus.stall_out); end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL mid_stall_drop: got %b expected 0", bus.stall_out); end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    ref_rdata = '0;
    err_exp   = 1'b0;
    @(posedge clk); #1;
    mem_op(1'b1, 1'b0, 16'h0020, 16'h0000);
    ref_rdata = ref_mem[16'h20];
    checks++; if (op_rdata !== 16'h1111) begin errors++; $display("FAIL mid_no_store: got %h expected 1111", op_rdata); end
  endtask

  task automatic test_wrap();
    logic [DSIZE-1:0] exp_v;
    mem_op(1'b0, 1'b1, 16'h0003, 16'h5A5A);
    ref_mem[16'h3] = 16'h5A5A;
    mem_op(1'b0, 1'b1, 16'((1 << MEM_AW) + 3), 16'h7777);
    checks++; if (op_stall != W + 1) begin errors++; $display("FAIL wrap_stall_len: got %0d expected %0d", op_stall, W + 1); end
`ifdef DM_RANGE_CHECK_EN
    err_exp = 1'b1;
`else
    ref_mem[16'h3] = 16'h7777;
`endif
    mem_op(1'b1, 1'b0, 16'h0003, 16'h0000);
    exp_v = ref_mem[16'h3];
    ref_rdata = exp_v;
    checks++; if (op_rdata !== exp_v) begin errors++; $display("FAIL wrap_rdata: got %h expected %h", op_rdata, exp_v); end
    checks++; if (bus.err_out !== err_exp) begin errors++; $display("FAIL wrap_err: got %b expected %b", bus.err_out, err_exp); end
  endtask

  task automatic test_back_to_back();
    int s1;
    mem_op(1'b1, 1'b0, 16'h0010, 16'h0000);
    s1 = op_start;
    checks++; if (op_rdata !== ref_mem[16'h10]) begin errors++; $display("FAIL b2b_rdata1: got %h expected %h", op_rdata, ref_mem[16'h10]); end
    mem_op(1'b1, 1'b0, 16'h0030, 16'h0000);
    ref_rdata = ref_mem[16'h30];
    checks++; if (op_start - s1 != W + 2) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", op_start - s1, W + 2); end
    checks++; if (op_rdata !== ref_mem[16'h30]) begin errors++; $display("FAIL b2b_rdata2: got %h expected %h", op_rdata, ref_mem[16'h30]); end
  endtask

  task automatic test_random();
    logic [DSIZE-1:0] a;
    logic [DSIZE-1:0] wd;
    logic [DSIZE-1:0] exp_v;
    logic             rd;
    logic             wr;
    int               kind;
    int               exp_stall;
    for (int i = 0; i < 8; i++) begin
      wd = 16'($urandom);
      mem_op(1'b0, 1'b1, 16'(16'h40 + i), wd);
      ref_mem[16'h40 + i] = wd;
    end
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 3);
      rd = (kind == 1) || (kind == 3);
      wr = (kind == 2) || (kind == 3);
      a  = 16'(16'h40 + $urandom_range(0, 7));
      wd = 16'($urandom);
      exp_stall = (rd || wr) ? W + 1 : 0;
      if (rd) ref_rdata = ref_mem[a];
      exp_q.push_back(ref_rdata);
      if (wr) ref_mem[a] = wd;
      mem_op(rd, wr, a, wd);
      exp_v = exp_q.pop_front();
      checks++; if (op_rdata !== exp_v) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, op_rdata, exp_v); end
      checks++; if (op_stall != exp_stall) begin errors++; $display("FAIL rand_stall[%0d]: got %0d expected %0d", i, op_stall, exp_stall); end
      checks++; if (op_leak !== 1'b0 || op_we !== 1'b1) begin errors++; $display("FAIL rand_we[%0d]: got leak=%b done=%b expected leak=0 done=1", i, op_leak, op_we); end
    end
    checks++; if (bus.err_out !== err_exp) begin errors++; $display("FAIL rand_err_sticky: got %b expected %b", bus.err_out, err_exp); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_passthrough();
    test_store_load();
    test_rmw();
    test_reset_mid_access();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
